// File: rtl/svga_timing_pattern_if.sv
// Video source bundle for svga_timing_pattern: pixel-enable and pattern select
// flow into the generator; colour, syncs, data-enable and frame marker flow out.
interface svga_timing_pattern_if #(
    parameter int COLOR_W = 4
);
    logic               pix_ce;
    logic [1:0]         mode;
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
    logic               hsync;
    logic               vsync;
    logic               de;
    logic               frame_start;

    // Generator side
    modport master (
        input  pix_ce, mode,
        output red, green, blue, hsync, vsync, de, frame_start
    );

    // Display / consumer side
    modport slave (
        output pix_ce, mode,
        input  red, green, blue, hsync, vsync, de, frame_start
    );
endinterface

// File: rtl/svga_timing_pattern.sv
// Raster timing generator and test-pattern source. Runs on one system clock;
// the raster advances one pixel on each clk with pix_ce=1. Every output is
// registered one pixel step after the x/y state it describes, so all outputs
// stay mutually aligned.
// Optional feature macro: SVGA_EXT_PATTERN_EN adds crosshatch, grey ramp and
// solid white (mode 1..3). Without it mode is ignored and bars are always shown.
module svga_timing_pattern #(
    parameter int H_ACTIVE   = 800,
    parameter int H_FP       = 40,
    parameter int H_SYNC     = 128,
    parameter int H_BP       = 88,
    parameter int V_ACTIVE   = 600,
    parameter int V_FP       = 1,
    parameter int V_SYNC     = 4,
    parameter int V_BP       = 23,
    parameter bit HS_POL     = 1'b1,
    parameter bit VS_POL     = 1'b1,
    parameter int COLOR_W    = 4,
    parameter int RAMP_SHIFT = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    svga_timing_pattern_if.master vid
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int XW      = $clog2(H_TOTAL);
    localparam int YW      = $clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;
    localparam int BCW     = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [BCW-1:0]     BAR_LAST = BCW'(BAR_W - 1);
    localparam logic [COLOR_W-1:0] FULL     = '1;
    localparam logic [COLOR_W-1:0] L75      = COLOR_W'((((1 << COLOR_W) - 1) * 3) >> 2);

    logic [XW-1:0]  x;
    logic [YW-1:0]  y;
    logic [BCW-1:0] bar_cnt;
    logic [2:0]     bar_idx;

    logic x_last, y_last, at_origin, vis, hs_on, vs_on;
    logic [2:0]         bar_bits;
    logic [COLOR_W-1:0] pr, pg, pb;

    logic [COLOR_W-1:0] red_q, green_q, blue_q;
    logic               hsync_q, vsync_q, de_q, fs_q;

    // Raster position decode; sync windows compared in int so a porch of 0 cannot overflow XW/YW
    always_comb begin
        x_last    = (x == XW'(H_TOTAL - 1));
        y_last    = (y == YW'(V_TOTAL - 1));
        at_origin = (x == '0) && (y == '0);
        vis       = (int'(x) < H_ACTIVE) && (int'(y) < V_ACTIVE);
        hs_on     = (int'(x) >= H_ACTIVE + H_FP) && (int'(x) < H_ACTIVE + H_FP + H_SYNC);
        vs_on     = (int'(y) >= V_ACTIVE + V_FP) && (int'(y) < V_ACTIVE + V_FP + V_SYNC);
    end

    // x/y raster counters plus bar counter that replaces an x / BAR_W divider
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x       <= '0;
            y       <= '0;
            bar_cnt <= '0;
            bar_idx <= 3'd0;
        end else if (vid.pix_ce) begin
            if (x_last) begin
                x       <= '0;
                y       <= y_last ? '0 : y + YW'(1);
                bar_cnt <= '0;
                bar_idx <= 3'd0;
            end else begin
                x <= x + XW'(1);
                if (bar_cnt == BAR_LAST) begin
                    bar_cnt <= '0;
                    // bar 7 absorbs the remainder when H_ACTIVE is not a multiple of 8
                    if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
                end else begin
                    bar_cnt <= bar_cnt + BCW'(1);
                end
            end
        end
    end

`ifdef SVGA_EXT_PATTERN_EN
    logic [1:0]         mode_q;
    logic [1:0]         pat_mode;
    logic               hatch;
    logic [COLOR_W-1:0] ramp;

    // Mode is captured only on the step at pixel (0,0) so a frame never changes pattern mid-way
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      mode_q <= 2'd0;
        else if (vid.pix_ce && at_origin) mode_q <= vid.mode;
    end

    // Pixel (0,0) already uses the value being latched on that step
    assign pat_mode = at_origin ? vid.mode : mode_q;
    assign hatch    = ((x & XW'(15)) == '0) || ((y & YW'(15)) == '0) ||
                      (x == XW'(H_ACTIVE - 1)) || (y == YW'(V_ACTIVE - 1));
    assign ramp     = COLOR_W'(x >> RAMP_SHIFT);
`else
    logic unused_mode;
    localparam int unused_ramp_shift = RAMP_SHIFT;
    assign unused_mode = ^vid.mode;
`endif

    // Colour of the current raster position; black outside the visible area
    always_comb begin
        case (bar_idx)
            3'd0:    bar_bits = 3'b111;  // white
            3'd1:    bar_bits = 3'b110;  // yellow
            3'd2:    bar_bits = 3'b011;  // cyan
            3'd3:    bar_bits = 3'b010;  // green
            3'd4:    bar_bits = 3'b101;  // magenta
            3'd5:    bar_bits = 3'b100;  // red
            3'd6:    bar_bits = 3'b001;  // blue
            default: bar_bits = 3'b000;  // black
        endcase
        pr = '0;
        pg = '0;
        pb = '0;
        if (vis) begin
`ifdef SVGA_EXT_PATTERN_EN
            case (pat_mode)
                2'd1: begin
                    if (hatch) begin
                        pr = FULL;
                        pg = FULL;
                        pb = FULL;
                    end
                end
                2'd2: begin
                    pr = ramp;
                    pg = ramp;
                    pb = ramp;
                end
                2'd3: begin
                    pr = FULL;
                    pg = FULL;
                    pb = FULL;
                end
                default: begin
                    pr = bar_bits[2] ? L75 : '0;
                    pg = bar_bits[1] ? L75 : '0;
                    pb = bar_bits[0] ? L75 : '0;
                end
            endcase
`else
            pr = bar_bits[2] ? L75 : '0;
            pg = bar_bits[1] ? L75 : '0;
            pb = bar_bits[0] ? L75 : '0;
`endif
        end
    end

    // Output register: one step behind the counters; frame_start is a single-clk pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            red_q   <= '0;
            green_q <= '0;
            blue_q  <= '0;
            hsync_q <= ~HS_POL;
            vsync_q <= ~VS_POL;
            de_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else if (vid.pix_ce) begin
            red_q   <= pr;
            green_q <= pg;
            blue_q  <= pb;
            hsync_q <= hs_on ? HS_POL : ~HS_POL;
            vsync_q <= vs_on ? VS_POL : ~VS_POL;
            de_q    <= vis;
            fs_q    <= at_origin;
        end else begin
            fs_q    <= 1'b0;
        end
    end

    assign vid.red         = red_q;
    assign vid.green       = green_q;
    assign vid.blue        = blue_q;
    assign vid.hsync       = hsync_q;
    assign vid.vsync       = vsync_q;
    assign vid.de          = de_q;
    assign vid.frame_start = fs_q;

endmodule

// File: tb/tb_svga_timing_pattern.sv
// Bench for svga_timing_pattern: a default-parameter instance for line timing
// and bar boundaries, and a small-parameter instance (22 x 7 raster) for whole
// frames, pix_ce duty, frame-synchronous mode changes and mid-line reset.
module tb_svga_timing_pattern;

`ifdef SVGA_EXT_PATTERN_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic clk160 = 1'b0;
    always #5 clk160 = ~clk160;

    logic rst_d_n;
    logic rst_s_n;
    int   tests_run    = 0;
    int   tests_failed = 0;

    svga_timing_pattern_if #(.COLOR_W(4)) if_d ();
    svga_timing_pattern_if #(.COLOR_W(4)) if_s ();

    svga_timing_pattern dut_d (
        .clk   (clk160),
        .rst_n (rst_d_n),
        .vid   (if_d)
    );

    svga_timing_pattern #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4),  .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b1), .COLOR_W(4), .RAMP_SHIFT(2)
    ) dut_s (
        .clk   (clk160),
        .rst_n (rst_s_n),
        .vid   (if_s)
    );

    // {de, hsync, vsync, frame_start, red, green, blue}
    logic [15:0] obs_d, obs_s;
    assign obs_d = {if_d.de, if_d.hsync, if_d.vsync, if_d.frame_start, if_d.red, if_d.green, if_d.blue};
    assign obs_s = {if_s.de, if_s.hsync, if_s.vsync, if_s.frame_start, if_s.red, if_s.green, if_s.blue};

    task automatic tick();
        @(posedge clk160);
        #1;
    endtask

    function automatic logic [11:0] bar_rgb(int idx);
        case (idx)
            0:       return 12'hBBB;
            1:       return 12'hBB0;
            2:       return 12'h0BB;
            3:       return 12'h0B0;
            4:       return 12'hB0B;
            5:       return 12'hB00;
            6:       return 12'h00B;
            default: return 12'h000;
        endcase
    endfunction

    // Expected small-raster output for pixel index p (counted from (0,0)) in pattern m
    function automatic logic [15:0] exp_small(int p, int m);
        int x, y;
        logic de, hs, vs, fs;
        logic [3:0]  lvl;
        logic [11:0] rgb;
        x   = p % 22;
        y   = (p / 22) % 7;
        de  = (x < 16) && (y < 4);
        hs  = !((x >= 18) && (x < 20));
        vs  = (y == 5);
        fs  = (x == 0) && (y == 0);
        rgb = 12'h000;
        if (de) begin
            case (m)
                1: if (x == 0 || y == 0 || x == 15 || y == 3) rgb = 12'hFFF;
                2: begin
                    lvl = 4'(x / 4);
                    rgb = {lvl, lvl, lvl};
                end
                3: rgb = 12'hFFF;
                default: rgb = bar_rgb(x / 2);
            endcase
        end
        return {de, hs, vs, fs, rgb};
    endfunction

    function automatic logic [1:0] mode_sched(int p);
        if (p < 30)  return 2'd0;
        if (p < 200) return 2'd2;
        if (p < 462) return 2'd1;
        return 2'd3;
    endfunction

    function automatic int frame_mode(int f);
        int m;
        case (f)
            0:       m = 0;
            1:       m = 2;
            2:       m = 1;
            default: m = 3;
        endcase
        return EXT ? m : 0;
    endfunction

    task automatic small_reset(logic [1:0] m);
        if_s.mode   = m;
        if_s.pix_ce = 1'b1;
        rst_s_n     = 1'b0;
        tick();
        tick();
        rst_s_n     = 1'b1;
    endtask

    task automatic test_reset();
        if_d.mode   = 2'd0;
        if_d.pix_ce = 1'b1;
        rst_d_n     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (obs_d !== 16'h0000) begin
                tests_failed++;
                $display("FAIL reset_hold[%0d]: got %h expected %h", i, obs_d, 16'h0000);
            end
        end
        rst_d_n = 1'b1;
        tick();
        tests_run++;
        if (obs_d !== 16'h9BBB) begin
            tests_failed++;
            $display("FAIL reset_first_pixel: got %h expected %h", obs_d, 16'h9BBB);
        end
    endtask

    task automatic test_line_timing();
        int hs_start0 = -1;
        int hs_start1 = -1;
        int hs_cnt0   = 0;
        int de_cnt1   = 0;
        int fs_cnt    = 0;
        int vs_cnt    = 0;
        int black_bad = 0;
        logic [15:0] exp;
        for (int p = 1; p <= 2112; p++) begin
            tick();
            if (p < 1056 && if_d.hsync === 1'b1) begin
                hs_cnt0++;
                if (hs_start0 < 0) hs_start0 = p;
            end
            if (p >= 1056 && p < 2112 && if_d.hsync === 1'b1 && hs_start1 < 0) hs_start1 = p;
            if (p >= 1056 && p < 2112 && if_d.de === 1'b1) de_cnt1++;
            if (if_d.frame_start !== 1'b0) fs_cnt++;
            if (if_d.vsync !== 1'b0) vs_cnt++;
            if (p >= 700 && p <= 799 && obs_d !== 16'h8000) black_bad++;
            if (p == 99 || p == 100 || p == 699 || p == 799 || p == 900) begin
                case (p)
                    99:      exp = 16'h8BBB;
                    100:     exp = 16'h8BB0;
                    699:     exp = 16'h800B;
                    799:     exp = 16'h8000;
                    default: exp = 16'h4000;
                endcase
                tests_run++;
                if (obs_d !== exp) begin
                    tests_failed++;
                    $display("FAIL bar_pixel[%0d]: got %h expected %h", p, obs_d, exp);
                end
            end
        end
        tests_run++;
        if (hs_start0 != 840) begin
            tests_failed++;
            $display("FAIL hsync_start: got %0d expected 840", hs_start0);
        end
        tests_run++;
        if (hs_cnt0 != 128) begin
            tests_failed++;
            $display("FAIL hsync_width: got %0d expected 128", hs_cnt0);
        end
        tests_run++;
        if (hs_start1 - hs_start0 != 1056) begin
            tests_failed++;
            $display("FAIL line_period: got %0d expected 1056", hs_start1 - hs_start0);
        end
        tests_run++;
        if (de_cnt1 != 800) begin
            tests_failed++;
            $display("FAIL de_per_line: got %0d expected 800", de_cnt1);
        end
        tests_run++;
        if (fs_cnt != 0 || vs_cnt != 0) begin
            tests_failed++;
            $display("FAIL no_fs_vs_lines01: got fs=%0d vs=%0d expected 0 0", fs_cnt, vs_cnt);
        end
        tests_run++;
        if (black_bad != 0) begin
            tests_failed++;
            $display("FAIL black_bar: got %0d bad pixels expected 0", black_bad);
        end
        tests_run++;
        if (obs_d !== 16'h8BBB) begin
            tests_failed++;
            $display("FAIL line2_start: got %h expected %h", obs_d, 16'h8BBB);
        end
    endtask

    task automatic test_hold();
        if_d.pix_ce = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if (obs_d !== 16'h8BBB) begin
                tests_failed++;
                $display("FAIL hold[%0d]: got %h expected %h", i, obs_d, 16'h8BBB);
            end
        end
        if_d.pix_ce = 1'b1;
        tick();
        tests_run++;
        if (obs_d !== 16'h8BBB) begin
            tests_failed++;
            $display("FAIL hold_resume: got %h expected %h", obs_d, 16'h8BBB);
        end
        if_d.pix_ce = 1'b0;
    endtask

    task automatic test_small_frame();
        logic [15:0] exp;
        if_s.mode   = 2'd0;
        if_s.pix_ce = 1'b1;
        rst_s_n     = 1'b0;
        tick();
        tests_run++;
        if (obs_s !== 16'h4000) begin
            tests_failed++;
            $display("FAIL small_reset: got %h expected %h", obs_s, 16'h4000);
        end
        rst_s_n = 1'b1;
        for (int p = 0; p <= 308; p++) begin
            tick();
            exp = exp_small(p, 0);
            tests_run++;
            if (obs_s !== exp) begin
                tests_failed++;
                $display("FAIL small_frame[%0d]: got %h expected %h", p, obs_s, exp);
            end
        end
    endtask

    task automatic test_duty();
        int e = 0;
        logic ce;
        logic [15:0] exp;
        small_reset(2'd0);
        for (int c = 0; c < 640; c++) begin
            ce          = (c % 4 == 0);
            if_s.pix_ce = ce;
            tick();
            if (ce) e++;
            exp = exp_small(e - 1, 0);
            if (!ce) exp[12] = 1'b0;
            tests_run++;
            if (obs_s !== exp) begin
                tests_failed++;
                $display("FAIL duty[clk %0d]: got %h expected %h", c, obs_s, exp);
            end
        end
    endtask

    task automatic test_mode_switch();
        logic [15:0] exp;
        small_reset(2'd0);
        for (int p = 0; p < 616; p++) begin
            if_s.mode = mode_sched(p);
            tick();
            exp = exp_small(p, frame_mode(p / 154));
            tests_run++;
            if (obs_s !== exp) begin
                tests_failed++;
                $display("FAIL mode_switch[%0d]: got %h expected %h", p, obs_s, exp);
            end
        end
        if_s.mode = 2'd0;
    endtask

    task automatic test_reset_midline();
        logic [15:0] exp;
        small_reset(2'd0);
        for (int p = 0; p < 40; p++) tick();
        rst_s_n = 1'b0;
        #1;
        tests_run++;
        if (obs_s !== 16'h4000) begin
            tests_failed++;
            $display("FAIL midline_async_reset: got %h expected %h", obs_s, 16'h4000);
        end
        tick();
        tests_run++;
        if (obs_s !== 16'h4000) begin
            tests_failed++;
            $display("FAIL midline_reset_hold: got %h expected %h", obs_s, 16'h4000);
        end
        rst_s_n = 1'b1;
        for (int p = 0; p < 6; p++) begin
            tick();
            exp = exp_small(p, 0);
            tests_run++;
            if (obs_s !== exp) begin
                tests_failed++;
                $display("FAIL midline_restart[%0d]: got %h expected %h", p, obs_s, exp);
            end
        end
    endtask

    initial begin
        rst_d_n     = 1'b0;
        rst_s_n     = 1'b0;
        if_d.pix_ce = 1'b0;
        if_d.mode   = 2'd0;
        if_s.pix_ce = 1'b0;
        if_s.mode   = 2'd0;
        test_reset();
        test_line_timing();
        test_hold();
        test_small_frame();
        test_duty();
        test_mode_switch();
        test_reset_midline();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/svga_timing_pattern.md
# svga_timing_pattern

Parametrised raster timing generator and test-pattern source for the VGA/SVGA output path. It runs on a single system clock with a pixel clock-enable, so the design needs no derived clock or ripple-clocked counters. It produces hsync, vsync, data-enable and RGB, all registered and aligned. Timing, sync polarity, colour depth and pattern mode are configurable, and mode changes are frame-synchronous.

## Interface
- H_ACTIVE, 800: visible pixels per line
- H_FP, 40: horizontal front porch, pixels
- H_SYNC, 128: hsync width, pixels
- H_BP, 88: horizontal back porch, pixels
- V_ACTIVE, 600: visible lines
- V_FP, 1: vertical front porch, lines
- V_SYNC, 4: vsync width, lines
- V_BP, 23: vertical back porch, lines
- HS_POL, 1: hsync active level
- VS_POL, 1: vsync active level
- COLOR_W, 4: bits per colour channel
- RAMP_SHIFT, 6: ramp level advances every 2^RAMP_SHIFT pixels
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- pix_ce  in  1  pixel enable; one pixel advances per clk with pix_ce=1
- mode  in  2  pattern select: 0 bars, 1 crosshatch, 2 grey ramp, 3 solid white
- red, green, blue  out  COLOR_W  pixel colour
- hsync  out  1  horizontal sync, polarity HS_POL
- vsync  out  1  vertical sync, polarity VS_POL
- de  out  1  high during visible pixels
- frame_start  out  1  one-clk pulse, aligned with output pixel (0,0)

## Operation
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise. x and y counters are $clog2(H_TOTAL) and $clog2(V_TOTAL) bits wide.
- Line order is active, FP, sync, BP:
  - x 0..H_ACTIVE-1 visible.
  - hsync active for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
- The same order applies to y and vsync. vsync changes only at x=0.
- x wraps H_TOTAL-1→0 and increments y. y wraps V_TOTAL-1→0.
- mode is latched into mode_q only at the pixel step where x=0, y=0. A mid-frame change takes effect at the next frame.
- Bars (mode 0):
  - BAR_W = H_ACTIVE/8 (integer). A bar counter is used, not a divider.
  - The bar index resets at x=0, increments every BAR_W pixels and saturates at 7, so bar 7 absorbs the remainder.
  - Order: white, yellow, cyan, green, magenta, red, blue, black.
  - "On" level L75 = ((2^COLOR_W-1)*3)>>2, which is 0xB for COLOR_W=4.
- Crosshatch (mode 1): full-scale white where x[3:0]==0, y[3:0]==0, x==H_ACTIVE-1 or y==V_ACTIVE-1; black elsewhere.
- Ramp (mode 2): all channels = (x>>RAMP_SHIFT) truncated to COLOR_W bits, wrapping.
- Solid (mode 3): all channels full scale.
- Outside the visible area, RGB = 0 and de = 0.

## Timing
- Reset (async assert, sync release) sets:
  - x, y, mode_q = 0; de = 0; RGB = 0; frame_start = 0.
  - hsync = !HS_POL; vsync = !VS_POL.
- Latency: outputs are registered one pix_ce step after the counter state they describe. All outputs are mutually aligned.
- pix_ce=0: counters and all outputs hold, except frame_start, which is forced to 0 on any clk with pix_ce=0.
- First pix_ce after reset release outputs pixel (0,0) with frame_start=1 and de=1.
- Reset mid-frame: immediate return to reset values. The raster restarts at (0,0) and does not complete the partial frame.
- mode changing on the same pix_ce step as the frame wrap is sampled; that new value applies to the frame starting there.

## Configuration
- SVGA_EXT_PATTERN_EN defined: modes 1–3 are implemented as above.
- Undefined: mode is ignored, mode_q logic is removed, and the output is always colour bars. Timing and sync behaviour are identical.

## Test plan
- Reset with pix_ce=1 held: outputs equal reset values while rst_n=0. On the first step after release, de=1, frame_start=1 and RGB=B,B,B (mode 0).
- Default params, one full frame with pix_ce=1:
  - Line period 1056 and frame period 628×1056 clks.
  - hsync high 128 clks, starting 840 steps after x=0.
  - vsync high 4 lines.
  - de count 480000.
  - Exactly one frame_start per frame.
- Mode 0 boundary: pixel 99 = (B,B,B); pixel 100 = (B,B,0); pixel 699 = (0,0,B); pixel 700..799 = (0,0,0).
- pix_ce at 1/4 duty (1,0,0,0): output sequence matches the pix_ce=1 run sample-for-sample, and frame_start stays a one-clk pulse.
- mode 0→2 asserted mid-frame: bars persist to frame end; the next frame shows ramp, with pixel 64=1 and pixel 799=12.
- Small params (H_ACTIVE=16, H_FP=H_SYNC=H_BP=2, V_ACTIVE=4, V_FP=V_SYNC=V_BP=1, HS_POL=0):
  - Correct wraps; hsync low 2 clks per line.
  - rst_n pulsed mid-line restarts at (0,0).
